ddr_axi_traffic_master: RTL and testbench
=========================================

DDR_AXI_TRAFFIC_MASTER -- requirements
Module: ddr_axi_traffic_master

Interface
REQ-001 The block SHALL be the initiator driving one DDR controller AXI slave port (axi_slvN_*); it has one clock, core_clk, and an asynchronous active-high reset, core_rst.
REQ-002 Parameter CTRL_ADDR_WIDTH, default 28: AXI byte-address width.
REQ-003 Parameter MEM_DQ_WIDTH, default 32: DDR DQ width. The AXI data width is MEM_DQ_WIDTH*8 (256) and the strobe width is MEM_DQ_WIDTH (32).
REQ-004 core_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 core_rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  in  1  1 = write burst, 0 = read-and-check burst.
REQ-009 cmd_addr  in  CTRL_ADDR_WIDTH  burst start address.
REQ-010 cmd_len  in  4  beats minus 1 (1..16 beats).
REQ-011 cmd_id  in  4  transaction ID.
REQ-012 cmd_seed  in  32  data pattern seed.
REQ-013 axi_awaddr / axi_araddr  out  CTRL_ADDR_WIDTH  burst address.
REQ-014 axi_awlen / axi_arlen  out  4  burst length.
REQ-015 axi_awuser_id / axi_aruser_id  out  4  burst ID.
REQ-016 axi_awuser_ap / axi_aruser_ap  out  1  auto-precharge, constant 0.
REQ-017 axi_awvalid / axi_arvalid  out  1  address valid.
REQ-018 axi_awready / axi_arready  in  1  address accepted.
REQ-019 axi_wdata  out  MEM_DQ_WIDTH*8  write data.
REQ-020 axi_wstrb  out  MEM_DQ_WIDTH  write strobes, constant all-ones.
REQ-021 axi_wready  in  1  slave consumes the current wdata beat this cycle (there is no wvalid).
REQ-022 axi_rdata  in  MEM_DQ_WIDTH*8  read data.
REQ-023 axi_rid  in  4  read ID.
REQ-024 axi_rlast  in  1  last read beat.
REQ-025 axi_rvalid  in  1  read beat valid; always accepted (there is no rready).
REQ-026 done  out  1  one-cycle pulse at burst completion.
REQ-027 err  out  1  one-cycle pulse per mismatching read beat.
REQ-028 err_cnt  out  16  saturating count of mismatching read beats.

Function
REQ-029 The FSM SHALL have states IDLE, AW, WDAT, AR and RDAT; cmd_ready SHALL be 1 only in IDLE.
REQ-030 On cmd_valid&cmd_ready in IDLE, the block SHALL latch all cmd_* fields, clear beat_cnt and go to AW if cmd_write=1, otherwise to AR.
REQ-031 In AW/AR, the block SHALL hold a*valid=1 with address, len and id stable until a*ready=1; it then leaves for WDAT/RDAT on the next cycle and deasserts a*valid.
REQ-032 Pattern: 32-bit lane k (k=0..7) of beat b SHALL equal cmd_seed + 8*b + k, modulo 2^32.
REQ-033 In WDAT, axi_wdata SHALL carry the pattern for the registered beat_cnt; each cycle with axi_wready=1 consumes one beat and increments beat_cnt.
REQ-034 WDAT SHALL end on axi_wready=1 with beat_cnt==len; the block then pulses done for one cycle and returns to IDLE.
REQ-035 In RDAT, each axi_rvalid=1 beat SHALL be compared against the expected pattern, axi_rid==id, and axi_rlast==(beat_cnt==len); any inequality SHALL raise err on the following cycle.
REQ-036 err_cnt SHALL increment once per erroneous beat and saturate at 16'hFFFF; only reset clears it.
REQ-037 RDAT SHALL end on axi_rvalid=1 with beat_cnt==len, regardless of rlast; the block then pulses done for one cycle and returns to IDLE.
REQ-038 A final-beat error SHALL produce err and done in the same cycle.
REQ-039 axi_wready outside WDAT and axi_rvalid outside RDAT SHALL be ignored, with no state change and no error.
REQ-040 cmd_len=0 SHALL produce a single-beat burst; beat_cnt SHALL never exceed len.
REQ-041 Back-to-back commands SHALL be supported: IDLE reached on the done cycle accepts a new command that same cycle.

Reset
REQ-042 While core_rst=1 (asynchronous), the state SHALL be IDLE and cmd_ready=1; a*valid, done, err, beat_cnt and err_cnt SHALL be 0, and axi_wdata, addr, len and id SHALL be 0.
REQ-043 Reset mid-burst SHALL abandon the burst immediately, drop a*valid asynchronously and produce no done pulse.

Structure
REQ-044 Package ddr_axi_pkg SHALL hold the FSM state enum, default CTRL_ADDR_WIDTH/MEM_DQ_WIDTH, and a pattern-lane function.
REQ-045 One sub-module, ddr_axi_pattern_gen (seed, beat -> 256-bit pattern), SHALL be shared by the write and compare paths.

Verification
REQ-046 Write, addr=0x100, len=3, seed=0, wready every other cycle -> awvalid held until awready; 4 beats with lane0 = 0, 8, 16, 24; done once.
REQ-047 Read back same, slave returns correct data with rid and rlast on beat 3 -> no err; err_cnt=0; done once.
REQ-048 Read, len=1, beat 1 lane 5 corrupted -> single err pulse coinciding with done; err_cnt=1.
REQ-049 Read, len=0, rlast missing, rid wrong -> one err; err_cnt=1; done.
REQ-050 core_rst asserted in WDAT after 2 beats -> awvalid=0 asynchronously, no done, cmd_ready=1 after release.
REQ-051 Stray rvalid/wready pulses in IDLE, seed=0xFFFFFFFC -> ignored; a subsequent write lane 7 of beat 0 = 0x00000003 (wrap).

Source files
------------

// File: rtl/ddr_axi_pkg.sv
// Shared types and helpers for the DDR AXI traffic master: FSM state
// encoding, default widths and the per-lane data pattern.
package ddr_axi_pkg;

  localparam int DEF_CTRL_ADDR_WIDTH = 28;
  localparam int DEF_MEM_DQ_WIDTH    = 32;
  localparam int LANE_WIDTH          = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    WDAT = 3'd2,
    AR   = 3'd3,
    RDAT = 3'd4
  } state_t;

  // Lane k of beat b is seed + 8*b + k, wrapping modulo 2^32.
  function automatic logic [31:0] pattern_lane(
    input logic [31:0] seed,
    input logic [3:0]  beat,
    input logic [7:0]  lane
  );
    return seed + {25'd0, beat, 3'd0} + {24'd0, lane};
  endfunction

endpackage

// File: rtl/ddr_axi_pattern_gen.sv
// Expands a seed and beat index into a full-width data pattern. One
// instance feeds both the write data bus and the read compare path, so
// written and checked data can never disagree by construction.
module ddr_axi_pattern_gen
  import ddr_axi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_MEM_DQ_WIDTH * 8
) (
  input  logic [31:0]           seed,
  input  logic [3:0]            beat,
  output logic [DATA_WIDTH-1:0] pattern
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign pattern[k*LANE_WIDTH +: LANE_WIDTH] = pattern_lane(seed, beat, 8'(k));
  end

endmodule

// File: rtl/ddr_axi_traffic_master.sv
// AXI initiator that drives one DDR controller slave port with patterned
// write bursts and read-and-check bursts. Commands arrive on a simple
// valid/ready interface; read mismatches are flagged per beat and counted.
module ddr_axi_traffic_master
  import ddr_axi_pkg::*;
#(
  parameter int CTRL_ADDR_WIDTH = DEF_CTRL_ADDR_WIDTH,
  parameter int MEM_DQ_WIDTH    = DEF_MEM_DQ_WIDTH
) (
  input  logic                       core_clk,
  input  logic                       core_rst,

  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [CTRL_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]                 cmd_len,
  input  logic [3:0]                 cmd_id,
  input  logic [31:0]                cmd_seed,

  output logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [3:0]                 axi_awlen,
  output logic [3:0]                 axi_awuser_id,
  output logic                       axi_awuser_ap,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,

  output logic [CTRL_ADDR_WIDTH-1:0] axi_araddr,
  output logic [3:0]                 axi_arlen,
  output logic [3:0]                 axi_aruser_id,
  output logic                       axi_aruser_ap,
  output logic                       axi_arvalid,
  input  logic                       axi_arready,

  output logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata,
  output logic [MEM_DQ_WIDTH-1:0]    axi_wstrb,
  input  logic                       axi_wready,

  input  logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata,
  input  logic [3:0]                 axi_rid,
  input  logic                       axi_rlast,
  input  logic                       axi_rvalid,

  output logic                       done,
  output logic                       err,
  output logic [15:0]                err_cnt
);

  localparam int DATA_WIDTH = MEM_DQ_WIDTH * 8;

  state_t                     state;
  logic [CTRL_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                 len_q;
  logic [3:0]                 id_q;
  logic [31:0]                seed_q;
  logic [3:0]                 beat_cnt;

  logic [DATA_WIDTH-1:0]      pattern;
  logic                       last_beat;
  logic                       rd_mismatch;

  ddr_axi_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern_gen (
    .seed    (seed_q),
    .beat    (beat_cnt),
    .pattern (pattern)
  );

  assign last_beat = (beat_cnt == len_q);

  // A read beat is bad if data, ID or the last-beat marker disagree.
  assign rd_mismatch = (axi_rdata != pattern) ||
                       (axi_rid != id_q) ||
                       (axi_rlast != last_beat);

  // Address channels both present the latched command; only the valid
  // flags distinguish which one is live.
  assign axi_awaddr    = addr_q;
  assign axi_awlen     = len_q;
  assign axi_awuser_id = id_q;
  assign axi_awuser_ap = 1'b0;
  assign axi_araddr    = addr_q;
  assign axi_arlen     = len_q;
  assign axi_aruser_id = id_q;
  assign axi_aruser_ap = 1'b0;

  // Write data is only driven during the data phase so the bus reads as
  // zero in reset and while idle.
  assign axi_wdata = (state == WDAT) ? pattern : '0;
  assign axi_wstrb = '1;

  // Command sequencing, beat counting, completion and error reporting.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      axi_awvalid <= 1'b0;
      axi_arvalid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= 16'd0;
      beat_cnt    <= 4'd0;
      addr_q      <= '0;
      len_q       <= 4'd0;
      id_q        <= 4'd0;
      seed_q      <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            id_q      <= cmd_id;
            seed_q    <= cmd_seed;
            beat_cnt  <= 4'd0;
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              state       <= AW;
              axi_awvalid <= 1'b1;
            end else begin
              state       <= AR;
              axi_arvalid <= 1'b1;
            end
          end
        end
        AW: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            state       <= WDAT;
          end
        end
        WDAT: begin
          if (axi_wready) begin
            if (last_beat) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        AR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            state       <= RDAT;
          end
        end
        RDAT: begin
          if (axi_rvalid) begin
            if (rd_mismatch) begin
              err <= 1'b1;
              if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
              end
            end
            if (last_beat) begin
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready   <= 1'b1;
          axi_awvalid <= 1'b0;
          axi_arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_axi_traffic_master.sv
// Directed bench for ddr_axi_traffic_master. Stimulus tasks push expected
// address requests, write beats and done/err events into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_ddr_axi_traffic_master;

  localparam int AWID = 28;
  localparam int DQ   = 32;
  localparam int DW   = DQ * 8;

  logic            core_clk;
  logic            core_rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AWID-1:0] cmd_addr;
  logic [3:0]      cmd_len;
  logic [3:0]      cmd_id;
  logic [31:0]     cmd_seed;
  logic [AWID-1:0] axi_awaddr;
  logic [3:0]      axi_awlen;
  logic [3:0]      axi_awuser_id;
  logic            axi_awuser_ap;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [AWID-1:0] axi_araddr;
  logic [3:0]      axi_arlen;
  logic [3:0]      axi_aruser_id;
  logic            axi_aruser_ap;
  logic            axi_arvalid;
  logic            axi_arready;
  logic [DW-1:0]   axi_wdata;
  logic [DQ-1:0]   axi_wstrb;
  logic            axi_wready;
  logic [DW-1:0]   axi_rdata;
  logic [3:0]      axi_rid;
  logic            axi_rlast;
  logic            axi_rvalid;
  logic            done;
  logic            err;
  logic [15:0]     err_cnt;

  ddr_axi_traffic_master #(
    .CTRL_ADDR_WIDTH (AWID),
    .MEM_DQ_WIDTH    (DQ)
  ) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .cmd_id        (cmd_id),
    .cmd_seed      (cmd_seed),
    .axi_awaddr    (axi_awaddr),
    .axi_awlen     (axi_awlen),
    .axi_awuser_id (axi_awuser_id),
    .axi_awuser_ap (axi_awuser_ap),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_araddr    (axi_araddr),
    .axi_arlen     (axi_arlen),
    .axi_aruser_id (axi_aruser_id),
    .axi_aruser_ap (axi_aruser_ap),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_wready    (axi_wready),
    .axi_rdata     (axi_rdata),
    .axi_rid       (axi_rid),
    .axi_rlast     (axi_rlast),
    .axi_rvalid    (axi_rvalid),
    .done          (done),
    .err           (err),
    .err_cnt       (err_cnt)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  typedef struct packed {
    logic [AWID-1:0] addr;
    logic [3:0]      len;
    logic [3:0]      id;
  } addr_exp_t;

  typedef struct packed {
    logic        err;
    logic        done;
    logic [15:0] cnt;
  } ev_exp_t;

  addr_exp_t     exp_aw[$];
  addr_exp_t     exp_ar[$];
  logic [DW-1:0] exp_w[$];
  ev_exp_t       exp_ev[$];

  addr_exp_t     mon_a;
  ev_exp_t       mon_ev;
  logic [DW-1:0] mon_w;

  int   n_checks      = 0;
  int   n_pass        = 0;
  int   model_err_cnt = 0;
  logic slave_wr_en   = 1'b0;
  logic check_wrap    = 1'b0;

  // Reference pattern: lane k of beat b = seed + 8*b + k (mod 2^32).
  function automatic logic [DW-1:0] model_beat(input logic [31:0] seed, input int b);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k*32 +: 32] = seed + 32'(8 * b + k);
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  // Present a command and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic wr, input logic [AWID-1:0] addr,
                               input logic [3:0] len, input logic [3:0] id,
                               input logic [31:0] seed);
    int t;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_id    = id;
    cmd_seed  = seed;
    cmd_valid = 1'b1;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) checkOutput("cmd_ready_timeout", 256'(cmd_ready), 256'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [AWID-1:0] addr, input logic [3:0] len,
                             input logic [3:0] id, input logic [31:0] seed,
                             input bit gap, input int aw_delay);
    exp_aw.push_back('{addr: addr, len: len, id: id});
    for (int b = 0; b <= int'(len); b++) exp_w.push_back(model_beat(seed, b));
    exp_ev.push_back('{err: 1'b0, done: 1'b1, cnt: 16'(model_err_cnt)});
    applyStimulus(1'b1, addr, len, id, seed);
    repeat (aw_delay) tick();
    if (aw_delay > 0) checkOutput("awvalid_hold", 256'(axi_awvalid), 256'(1));
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    checkOutput("awvalid_drop", 256'(axi_awvalid), 256'(0));
    for (int b = 0; b <= int'(len); b++) begin
      if (gap) begin
        axi_wready  = 1'b0;
        slave_wr_en = 1'b0;
        tick();
      end
      axi_wready  = 1'b1;
      slave_wr_en = 1'b1;
      tick();
    end
    axi_wready  = 1'b0;
    slave_wr_en = 1'b0;
  endtask

  task automatic read_burst(input logic [AWID-1:0] addr, input logic [3:0] len,
                            input logic [3:0] id, input logic [31:0] seed,
                            input int bad_beat, input int bad_lane,
                            input bit bad_rid, input bit no_rlast);
    bit bad;
    exp_ar.push_back('{addr: addr, len: len, id: id});
    for (int b = 0; b <= int'(len); b++) begin
      bad = (b == bad_beat) || bad_rid || (no_rlast && b == int'(len));
      if (bad) model_err_cnt++;
      if (bad || b == int'(len)) begin
        exp_ev.push_back('{err: bad, done: (b == int'(len)), cnt: 16'(model_err_cnt)});
      end
    end
    applyStimulus(1'b0, addr, len, id, seed);
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    checkOutput("arvalid_drop", 256'(axi_arvalid), 256'(0));
    for (int b = 0; b <= int'(len); b++) begin
      axi_rvalid = 1'b1;
      axi_rdata  = model_beat(seed, b);
      if (b == bad_beat) axi_rdata[bad_lane*32 +: 32] = axi_rdata[bad_lane*32 +: 32] ^ 32'h0000_0100;
      axi_rid    = bad_rid ? (id ^ 4'hF) : id;
      axi_rlast  = !no_rlast && (b == int'(len));
      tick();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rdata  = '0;
  endtask

  task automatic pulse_reset();
    core_rst = 1'b1;
    repeat (2) tick();
    core_rst      = 1'b0;
    model_err_cnt = 0;
    tick();
  endtask

  // Scoreboard monitor: compare DUT-presented outputs against queued expectations.
  always @(negedge core_clk) begin
    if (!core_rst) begin
      if (axi_awvalid && axi_awready) begin
        if (exp_aw.size() == 0) checkOutput("unexpected_aw", 256'(axi_awvalid), 256'(0));
        else begin
          mon_a = exp_aw.pop_front();
          checkOutput("aw_request", 256'({axi_awaddr, axi_awlen, axi_awuser_id}), 256'(mon_a));
        end
      end
      if (axi_arvalid && axi_arready) begin
        if (exp_ar.size() == 0) checkOutput("unexpected_ar", 256'(axi_arvalid), 256'(0));
        else begin
          mon_a = exp_ar.pop_front();
          checkOutput("ar_request", 256'({axi_araddr, axi_arlen, axi_aruser_id}), 256'(mon_a));
        end
      end
      if (axi_wready && slave_wr_en && exp_w.size() > 0) begin
        mon_w = exp_w.pop_front();
        checkOutput("wdata_beat", axi_wdata, mon_w);
        if (check_wrap) checkOutput("wrap_lane7", 256'(axi_wdata[255:224]), 256'(32'h0000_0003));
      end
      if (done || err) begin
        if (exp_ev.size() == 0) checkOutput("unexpected_event", 256'({err, done}), 256'(0));
        else begin
          mon_ev = exp_ev.pop_front();
          checkOutput("done_err_event", 256'({err, done, err_cnt}), 256'(mon_ev));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    core_rst    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_len     = 4'd0;
    cmd_id      = 4'd0;
    cmd_seed    = 32'd0;
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    axi_rdata   = '0;
    axi_rid     = 4'd0;
    axi_rlast   = 1'b0;
    axi_rvalid  = 1'b0;
    #2 core_rst = 1'b1;
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    checkOutput("rst_awvalid",   256'(axi_awvalid), 256'(0));
    checkOutput("rst_arvalid",   256'(axi_arvalid), 256'(0));
    checkOutput("rst_done_err",  256'({done, err}), 256'(0));
    checkOutput("rst_err_cnt",   256'(err_cnt), 256'(0));
    checkOutput("rst_wdata",     axi_wdata, '0);
    checkOutput("rst_aw_fields", 256'({axi_awaddr, axi_awlen, axi_awuser_id}), 256'(0));
    checkOutput("rst_wstrb",     256'(axi_wstrb), 256'(32'hFFFF_FFFF));
    checkOutput("ap_const",      256'({axi_awuser_ap, axi_aruser_ap}), 256'(0));
    core_rst = 1'b0;
    tick();

    $display("[TB] write 0x100 len 3 seed 0, wready every other cycle");
    write_burst(28'h100, 4'd3, 4'd5, 32'd0, 1'b1, 2);
    repeat (3) tick();

    $display("[TB] read back with correct data");
    read_burst(28'h100, 4'd3, 4'd5, 32'd0, -1, 0, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("read_ok_err_cnt", 256'(err_cnt), 256'(0));

    $display("[TB] read len 1, beat 1 lane 5 corrupted");
    read_burst(28'h200, 4'd1, 4'd2, 32'h1234_5678, 1, 5, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("corrupt_err_cnt", 256'(err_cnt), 256'(1));

    pulse_reset();
    $display("[TB] read len 0, rlast missing and rid wrong");
    read_burst(28'h300, 4'd0, 4'd7, 32'hA5A5_0000, -1, 0, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("single_beat_err_cnt", 256'(err_cnt), 256'(1));

    $display("[TB] async reset during AW");
    applyStimulus(1'b1, 28'h400, 4'd2, 4'd1, 32'd0);
    checkOutput("aw_valid_before_rst", 256'(axi_awvalid), 256'(1));
    #2 core_rst = 1'b1;
    #1 checkOutput("aw_async_drop", 256'({axi_awvalid, cmd_ready}), 256'(2'b01));
    tick();
    core_rst      = 1'b0;
    model_err_cnt = 0;
    tick();

    $display("[TB] async reset in WDAT after two beats");
    exp_aw.push_back('{addr: 28'h500, len: 4'd3, id: 4'd3});
    exp_w.push_back(model_beat(32'h10, 0));
    exp_w.push_back(model_beat(32'h10, 1));
    applyStimulus(1'b1, 28'h500, 4'd3, 4'd3, 32'h10);
    axi_awready = 1'b1;
    tick();
    axi_awready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      axi_wready  = 1'b1;
      slave_wr_en = 1'b1;
      tick();
    end
    axi_wready  = 1'b0;
    slave_wr_en = 1'b0;
    #3 core_rst = 1'b1;
    #1 checkOutput("wdat_rst_outputs", 256'({axi_awvalid, done, cmd_ready}), 256'(3'b001));
    checkOutput("wdat_rst_wdata", axi_wdata, '0);
    tick();
    core_rst      = 1'b0;
    model_err_cnt = 0;
    repeat (3) tick();
    checkOutput("post_rst_cmd_ready", 256'(cmd_ready), 256'(1));

    $display("[TB] stray rvalid/wready in IDLE");
    for (int i = 0; i < 4; i++) begin
      axi_rvalid = 1'b1;
      axi_rdata  = {8{32'hDEAD_BEEF}};
      axi_rid    = 4'd3;
      axi_rlast  = i[0];
      axi_wready = 1'b1;
      tick();
    end
    axi_rvalid = 1'b0;
    axi_rlast  = 1'b0;
    axi_rdata  = '0;
    axi_wready = 1'b0;
    tick();
    checkOutput("stray_ignored", 256'({cmd_ready, err, err_cnt}), 256'({1'b1, 1'b0, 16'd0}));

    $display("[TB] wrap write then back-to-back read");
    check_wrap = 1'b1;
    write_burst(28'h600, 4'd0, 4'd9, 32'hFFFF_FFFC, 1'b0, 0);
    check_wrap = 1'b0;
    checkOutput("b2b_ready_on_done", 256'({done, cmd_ready}), 256'(2'b11));
    read_burst(28'h600, 4'd0, 4'd9, 32'hFFFF_FFFC, -1, 0, 1'b0, 1'b0);
    repeat (5) tick();

    checkOutput("aw_queue_drained", 256'(exp_aw.size()), 256'(0));
    checkOutput("ar_queue_drained", 256'(exp_ar.size()), 256'(0));
    checkOutput("w_queue_drained",  256'(exp_w.size()),  256'(0));
    checkOutput("ev_queue_drained", 256'(exp_ev.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
